// File: rtl/adc128_scan.sv
// adc128_scan: scan controller for ADC128S022-class 8-channel 12-bit SPI ADCs.
//
// Walks a channel-enable mask, sending each channel address one frame ahead
// of its conversion. A scan of M enabled channels takes M+1 frames. Results
// appear as a per-sample strobe stream and as a packed per-channel bank.
//
// Optional feature macro: ADC128_AVG_EN. When it is defined, each data_o
// field carries the truncated mean of 4 consecutive samples, and scan_done_o
// pulses once every 4 scans.
//
// Ports:
//   clk_i, rst_n_i          system clock, async active-low reset
//   start_i, cont_i         single-scan pulse / continuous-mode level
//   ch_en_i[NUM_CH]         channel enable mask, latched at scan start
//   AD128_SCLK/CS/DIN       ADC serial outputs (SCLK idles high, CS active-low)
//   AD128_DOUT              ADC serial data in
//   busy_o                  scan in progress
//   smp_vld_o/ch_o/data_o   per-sample strobe, channel and data
//   data_o[12*NUM_CH]       packed results, channel i at [12i+11:12i]
//   scan_done_o             strobe, scan results complete
module adc128_scan #(
  parameter int NUM_CH   = 8,
  parameter int CLK_DIV  = 2,
  parameter int WAIT_CYC = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic [NUM_CH-1:0]      ch_en_i,
  output logic                   AD128_SCLK,
  output logic                   AD128_CS,
  output logic                   AD128_DIN,
  input  logic                   AD128_DOUT,
  output logic                   busy_o,
  output logic                   smp_vld_o,
  output logic [2:0]             smp_ch_o,
  output logic [11:0]            smp_data_o,
  output logic [12*NUM_CH-1:0]   data_o,
  output logic                   scan_done_o
);

  localparam int MAXC = (CLK_DIV > WAIT_CYC) ? CLK_DIV : WAIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [4:0]        half, half_d;      // SCLK half-period index within SHIFT
  logic [1:0]        rst_sync;
  logic [NUM_CH-1:0] mask;
  logic [2:0]        cur_ch;            // address sent in the current frame
  logic [2:0]        prev_ch;           // channel whose data arrives this frame
  logic              first_frm, final_frm;
  logic [11:0]       sreg;
  logic              cs_d, sclk_d, din_d, busy_d;
  logic              cnt_end, go_scan, rescan, gap_end, frame_end, cap_bit, relatch;
  logic [3:0]        nxt;

  // Lowest enabled channel of a mask.
  function automatic logic [2:0] first_en(input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest enabled channel above c.
  function automatic logic [3:0] next_en(input logic [NUM_CH-1:0] m, input logic [2:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // End of the current timed phase.
  always_comb begin
    case (state)
      LEAD, SHIFT: cnt_end = (cnt == DIV_LAST);
      GAP:         cnt_end = (cnt == GAP_LAST);
      default:     cnt_end = 1'b0;
    endcase
  end

  assign go_scan   = rst_sync[1] && (start_i || cont_i) && (ch_en_i != '0);
  assign rescan    = cont_i && (ch_en_i != '0);
  assign gap_end   = (state == GAP) && cnt_end;
  assign frame_end = (state == SHIFT) && cnt_end && (half == 5'd31);
  // Leaving an SCLK-low half = rising edge; data bits start at rising edge 5.
  assign cap_bit   = (state == SHIFT) && cnt_end && !half[0] && (half >= 5'd8);
  assign relatch   = ((state == IDLE) && go_scan) || (gap_end && final_frm && rescan);
  assign nxt       = next_en(mask, cur_ch);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      half  <= 5'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      half  <= half_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    half_d  = half;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (go_scan) state_d = LEAD;
        else         state_d = IDLE;
      end
      LEAD: begin
        if (cnt_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = 5'd0;
        end else begin
          state_d = LEAD;
        end
      end
      SHIFT: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (half == 5'd31) state_d = GAP;
          else               half_d  = half + 5'd1;
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = (final_frm && !rescan) ? IDLE : LEAD;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so pins are registered with the state.
  always_comb begin
    busy_d = (state_d != IDLE);
    cs_d   = !((state_d == LEAD) || (state_d == SHIFT));
    if (state_d == SHIFT) begin
      sclk_d = half_d[0];
      // Falling edges 3,4,5 (halves 4,6,8) carry A2,A1,A0.
      case (half_d[4:1])
        4'd2:    din_d = cur_ch[2];
        4'd3:    din_d = cur_ch[1];
        4'd4:    din_d = cur_ch[0];
        default: din_d = 1'b0;
      endcase
    end else begin
      sclk_d = 1'b1;
      din_d  = 1'b0;
    end
  end

  // Pin and busy output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      AD128_CS   <= 1'b1;
      AD128_SCLK <= 1'b1;
      AD128_DIN  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      AD128_CS   <= cs_d;
      AD128_SCLK <= sclk_d;
      AD128_DIN  <= din_d;
      busy_o     <= busy_d;
    end
  end

`ifdef ADC128_AVG_EN
  logic [13:0] acc [NUM_CH];
  logic [1:0]  scan_cnt;
  logic [13:0] acc_sel, acc_sum;

  // Accumulator of the channel being written, plus the new sample.
  always_comb begin
    acc_sel = 14'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (prev_ch == 3'(i)) acc_sel = acc[i];
      else                  acc_sel = acc_sel;
    end
    acc_sum = acc_sel + {2'b00, sreg};
  end
`endif

  // Channel sequencing, data capture and result delivery.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask        <= '0;
      cur_ch      <= 3'd0;
      prev_ch     <= 3'd0;
      first_frm   <= 1'b1;
      final_frm   <= 1'b0;
      sreg        <= 12'd0;
      smp_vld_o   <= 1'b0;
      smp_ch_o    <= 3'd0;
      smp_data_o  <= 12'd0;
      data_o      <= '0;
      scan_done_o <= 1'b0;
`ifdef ADC128_AVG_EN
      scan_cnt    <= 2'd0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= 14'd0;
`endif
    end else begin
      smp_vld_o   <= 1'b0;
      scan_done_o <= 1'b0;
      if (cap_bit) sreg <= {sreg[10:0], AD128_DOUT};

      if (relatch) begin
        mask      <= ch_en_i;
        cur_ch    <= first_en(ch_en_i);
        first_frm <= 1'b1;
        final_frm <= 1'b0;
`ifdef ADC128_AVG_EN
        if (ch_en_i != mask) begin
          scan_cnt <= 2'd0;
          for (int i = 0; i < NUM_CH; i++) acc[i] <= 14'd0;
        end
`endif
      end else if (gap_end && !final_frm) begin
        prev_ch   <= cur_ch;
        first_frm <= 1'b0;
        // When the mask is exhausted, resend the first channel to flush the pipeline.
        if (nxt[3]) begin
          cur_ch    <= nxt[2:0];
          final_frm <= 1'b0;
        end else begin
          cur_ch    <= first_en(mask);
          final_frm <= 1'b1;
        end
      end

      if (frame_end && !first_frm) begin
        smp_vld_o  <= 1'b1;
        smp_ch_o   <= prev_ch;
        smp_data_o <= sreg;
`ifdef ADC128_AVG_EN
        scan_done_o <= final_frm && (scan_cnt == 2'd3);
        if (final_frm) scan_cnt <= scan_cnt + 2'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (prev_ch == 3'(i)) begin
            if (scan_cnt == 2'd3) begin
              data_o[12*i +: 12] <= acc_sum[13:2];
              acc[i]             <= 14'd0;
            end else begin
              acc[i] <= acc_sum;
            end
          end
        end
`else
        scan_done_o <= final_frm;
        for (int i = 0; i < NUM_CH; i++) begin
          if (prev_ch == 3'(i)) data_o[12*i +: 12] <= sreg;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc128_scan.sv
// Self-checking bench for adc128_scan (NUM_CH=8, CLK_DIV=2, WAIT_CYC=4).
// The ADC model returns 0x100 + the address received in the previous frame
// (with ADC128_AVG_EN: 0x100 + a per-scan offset).
module tb_adc128_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont;
  logic [7:0]  ch_en;
  logic        sclk, cs, din, adc_dout;
  logic        busy, vld, done;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic [95:0] data;

  adc128_scan #(.NUM_CH(8), .CLK_DIV(2), .WAIT_CYC(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cont_i(cont), .ch_en_i(ch_en),
    .AD128_SCLK(sclk), .AD128_CS(cs), .AD128_DIN(din), .AD128_DOUT(adc_dout),
    .busy_o(busy), .smp_vld_o(vld), .smp_ch_o(smp_ch), .smp_data_o(smp_data),
    .data_o(data), .scan_done_o(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Monitor / ADC model state
  logic        cs_q = 1'b1, sclk_q = 1'b1, mon_clr = 1'b0;
  int          nbit = 0, low_len = 0, per_len = 0, ofs = 0;
  logic        per_run = 1'b0;
  logic [15:0] din_word = 16'd0;
  logic [11:0] cur_data = 12'd0;
  int          n_frames, n_done, n_busy, bad_cs, bad_per, bad_vld;
  logic [2:0]  addr_q[$];
  logic [14:0] smp_q[$];

  // ADC model and pin monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    per_len++;
    if (!busy) per_run = 1'b0;
    if (!cs && cs_q) begin
      n_frames++;
      nbit = 0; adc_dout = 1'b0; din_word = 16'd0; low_len = 0;
      if (per_run && per_len != 70) bad_per++;
      per_run = 1'b1; per_len = 0;
    end
    if (!cs) low_len++;
    if (!cs && !sclk && sclk_q) begin
      nbit++;
      adc_dout = (nbit >= 5 && nbit <= 16) ? cur_data[16-nbit] : 1'b0;
    end
    if (!cs && sclk && !sclk_q) din_word = {din_word[14:0], din};
    if (cs && !cs_q) begin
      addr_q.push_back(din_word[13:11]);
      if (low_len != 66) bad_cs++;
`ifdef ADC128_AVG_EN
      cur_data = 12'h100 + 12'(ofs);
`else
      cur_data = 12'h100 + {9'd0, din_word[13:11]};
`endif
    end
    if (vld) begin
      if (!(cs && !cs_q)) bad_vld++;
      smp_q.push_back({smp_ch, smp_data});
    end
    if (done) begin
      n_done++;
      if (!vld) bad_vld++;
    end
    if (busy) n_busy++;
    cs_q = cs; sclk_q = sclk;
    if (mon_clr) begin
      n_frames = 0; n_done = 0; n_busy = 0; bad_cs = 0; bad_per = 0; bad_vld = 0;
      addr_q.delete(); smp_q.delete();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " CS"}, {31'd0, cs}, 32'd1);
    check({tag, " SCLK"}, {31'd0, sclk}, 32'd1);
    check({tag, " DIN"}, {31'd0, din}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " vld"}, {31'd0, vld}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " smp_ch"}, {29'd0, smp_ch}, 32'd0);
    check({tag, " smp_data"}, {20'd0, smp_data}, 32'd0);
    check({tag, " data_o"}, {31'd0, |data}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Bounded waits on busy; an expired bound shows up as a failed check.
  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int t = 0;
    while (busy !== lvl && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'd0, busy}, {31'd0, lvl});
  endtask

  typedef struct {
    logic [7:0] mask;
    int         cont_len;     // 0: single start pulse, else cycles cont_i stays high
    int         extra_start;  // cycles into the scan for an ignored start pulse (0: none)
    int         scans;        // expected scan_done_o pulses
    int         frames;       // expected CS frames
  } vec_t;

  logic [11:0] exp_data [8];

`ifndef ADC128_AVG_EN
  task automatic run_row(input int r, input vec_t v);
    logic [2:0]  exp_addr[$];
    logic [14:0] exp_smp[$];
    logic [2:0]  first_ch;
    first_ch = 3'd0;
    for (int c = 7; c >= 0; c--) if (v.mask[c]) first_ch = 3'(c);
    for (int s = 0; s < v.scans; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (v.mask[c]) begin
          exp_addr.push_back(3'(c));
          exp_smp.push_back({3'(c), 12'h100 + 12'(c)});
        end
      end
      exp_addr.push_back(first_ch);
    end

    clear_mon();
    ch_en = v.mask;
    if (v.cont_len == 0) pulse_start();
    else @(negedge clk) cont = 1'b1;
    if (v.frames > 0) begin
      wait_busy(1'b1, 10, $sformatf("r%0d busy rise", r));
      if (v.extra_start > 0) begin
        repeat (v.extra_start) @(negedge clk);
        pulse_start();
      end
      if (v.cont_len > 0) begin
        repeat (v.cont_len) @(negedge clk);
        cont = 1'b0;
      end
      wait_busy(1'b0, 3000, $sformatf("r%0d busy fall", r));
    end else begin
      repeat (100) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    check($sformatf("r%0d frames", r), n_frames, v.frames);
    check($sformatf("r%0d scan_done", r), n_done, v.scans);
    check($sformatf("r%0d busy cycles", r), n_busy, v.frames * 70);
    check($sformatf("r%0d cs low len errs", r), bad_cs, 0);
    check($sformatf("r%0d frame period errs", r), bad_per, 0);
    check($sformatf("r%0d vld timing errs", r), bad_vld, 0);
    check($sformatf("r%0d addr count", r), addr_q.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < addr_q.size(); k++)
      check($sformatf("r%0d addr[%0d]", r, k), {29'd0, addr_q[k]}, {29'd0, exp_addr[k]});
    check($sformatf("r%0d sample count", r), smp_q.size(), exp_smp.size());
    for (int k = 0; k < exp_smp.size() && k < smp_q.size(); k++) begin
      check($sformatf("r%0d sample[%0d]", r, k), {17'd0, smp_q[k]}, {17'd0, exp_smp[k]});
      exp_data[exp_smp[k][14:12]] = exp_smp[k][11:0];
    end
    for (int c = 0; c < 8; c++)
      check($sformatf("r%0d data_o ch%0d", r, c), {20'd0, data[12*c +: 12]}, {20'd0, exp_data[c]});
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef ADC128_AVG_EN
    vec_t vecs [5];
`endif
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_en = 8'h00;
    for (int c = 0; c < 8; c++) exp_data[c] = 12'd0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef ADC128_AVG_EN
    clear_mon();
    ch_en = 8'h08;
    for (int s = 0; s < 4; s++) begin
      ofs = s;
      pulse_start();
      wait_busy(1'b1, 10, $sformatf("avg s%0d busy rise", s));
      wait_busy(1'b0, 3000, $sformatf("avg s%0d busy fall", s));
      repeat (5) @(negedge clk);
      check($sformatf("avg s%0d ch3 field", s), {20'd0, data[36 +: 12]}, (s == 3) ? 32'h101 : 32'h0);
      check($sformatf("avg s%0d scan_done", s), n_done, (s == 3) ? 1 : 0);
      check($sformatf("avg s%0d raw sample", s), {17'd0, smp_q[$]}, {17'd0, 3'd3, 12'h100 + 12'(s)});
    end
`else
    vecs[0] = '{mask: 8'hFF, cont_len: 0,   extra_start: 0,   scans: 1, frames: 9};
    vecs[1] = '{mask: 8'h81, cont_len: 0,   extra_start: 100, scans: 1, frames: 3};
    vecs[2] = '{mask: 8'h00, cont_len: 0,   extra_start: 0,   scans: 0, frames: 0};
    vecs[3] = '{mask: 8'h0F, cont_len: 875, extra_start: 0,   scans: 3, frames: 15};
    vecs[4] = '{mask: 8'h01, cont_len: 0,   extra_start: 0,   scans: 1, frames: 2};
    for (int r = 0; r < 5; r++) begin
      if (r == 3) begin
        // Reset in the middle of a frame's shift phase.
        ch_en = 8'hFF;
        pulse_start();
        repeat (20) @(negedge clk);
        check("mid busy before reset", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid-shift");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 8; c++) exp_data[c] = 12'd0;
      end
      run_row(r, vecs[r]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
